truth_table_sweeper: RTL
========================

Name: truth_table_sweeper

Overview:
- Sequencer for one 3-input combinational logic function under test (DUT), e.g. a gate such as m0x7B.
- On start, steps the DUT inputs through all 8 combinations, waits a settle time per combination, samples the DUT output and builds its 8-bit truth table.
- Compares the truth table against an expected code and reports match or mismatch.
- Used as the self-check controller that wraps each compiled truth-table gate.

Parameters:
- SETTLE_CYCLES, 4, cycles each input combination is held before the output is sampled; minimum 1.
- EXPECTED, 8'h7B, expected truth-table code for the DUT.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a sweep; sampled only in IDLE.
- abort  input  1  cancel the sweep in progress.
- dut_in  output  3  {in1,in2,in3} driven to the DUT.
- dut_out  input  1  DUT output.
- busy  output  1  high while a sweep is running.
- done  output  1  one-cycle pulse when a sweep completes.
- table_out  output  8  last completed truth table.
- match  output  1  table_out == EXPECTED; valid from done onward.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state IDLE; dut_in=3'b000; busy=0; done=0; table_out=8'h00; match=0; row counter and settle counter 0; shadow table 0.
- Truth-table encoding: bit [7-k] holds dut_out sampled while dut_in=k, where k={in1,in2,in3}. Row 000 maps to bit 7 and row 111 to bit 0, so a correct 0x7B gate yields 8'h7B.
- States are IDLE, SETTLE, DONE.
- IDLE:
  - start=1 and abort=0 at an edge -> SETTLE. On that edge: busy=1, row=0, dut_in=0, settle counter=0, shadow cleared.
  - Otherwise stay in IDLE with dut_in=0.
- SETTLE:
  - The counter increments each cycle.
  - On the edge where counter==SETTLE_CYCLES-1, dut_out is captured into shadow bit [7-row] and the counter resets.
  - If row<7 at that edge: row increments and dut_in updates on the same edge.
  - If row==7 at that edge: go to DONE.
  - Each row therefore drives dut_in for exactly SETTLE_CYCLES cycles.
- DONE (one cycle):
  - table_out<=shadow and match<=(shadow==EXPECTED) are registered on the edge entering DONE.
  - done=1 and busy=1 during this cycle.
  - Next edge -> IDLE, with busy=0 and dut_in=0.
- Latency: from the start-sampling edge to the done cycle is 8*SETTLE_CYCLES cycles (32 for the default). done is high during cycle 8*SETTLE_CYCLES+1 after start.
- abort:
  - In SETTLE or DONE, abort=1 -> IDLE on the next edge: busy=0, dut_in=0, no done.
  - On abort, table_out and match keep their previous values and the shadow table is discarded.
  - In DONE, abort does not suppress the done pulse already issued; table_out is already updated.
- Simultaneous start and abort in IDLE: abort wins and no sweep starts.
- start while busy is ignored and not queued.
- start held high continuously starts back-to-back sweeps. The next sweep begins at the edge after DONE→IDLE, since one IDLE cycle is mandatory.
- rst_n asserted mid-sweep immediately forces all reset values, including table_out=0 and match=0.
- dut_out is sampled directly; the DUT is combinational in the same clock domain.

Optional Feature:
- Macro TT_SWEEP_ERRCNT_EN.
- When defined:
  - Adds output err_count[7:0], reset to 0.
  - Increments on the done cycle when the completed table != EXPECTED.
  - Saturates at 8'hFF.
  - Aborted sweeps do not count.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset check: drive rst_n low with arbitrary inputs -> dut_in=0, busy=0, done=0, table_out=8'h00, match=0. Repeat with rst_n asserted asynchronously mid-sweep -> same values with no clock edge.
- Default sweep, DUT modelled as 0x7B: pulse start -> dut_in steps 0..7, 4 cycles each; done 32 cycles after start; table_out=8'h7B; match=1.
- Faulty DUT stuck at 0: sweep -> table_out=8'h00, match=0. Then an inverted 0x7B DUT -> table_out=8'h84, match=0.
- Abort with row=3 mid-settle -> busy=0 next cycle, dut_in=0, no done, table_out/match keep the prior sweep's values. A following start runs a full correct sweep.
- start pulsed during a sweep -> ignored, exactly one done. start and abort together in IDLE -> no sweep. start held high -> consecutive done pulses 34 cycles apart (SETTLE_CYCLES=4).
- With TT_SWEEP_ERRCNT_EN and a stuck-at-0 DUT:
  - 3 sweeps -> err_count=3.
  - Then a correct DUT -> err_count stays 3.
  - After forcing err_count=8'hFE, run 2 failing sweeps -> 8'hFF.

Source files
------------

// File: rtl/truth_table_sweeper_if.sv
// Control/status and DUT-side signals of the truth-table sweeper.
// Optional macro TT_SWEEP_ERRCNT_EN adds the err_count status bus.
interface truth_table_sweeper_if;
    logic       start;
    logic       abort;
    logic [2:0] dut_in;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic [7:0] table_out;
    logic       match;
`ifdef TT_SWEEP_ERRCNT_EN
    logic [7:0] err_count;

    modport master (
        output start, abort, dut_out,
        input  dut_in, busy, done, table_out, match, err_count
    );
    modport slave (
        input  start, abort, dut_out,
        output dut_in, busy, done, table_out, match, err_count
    );
`else
    modport master (
        output start, abort, dut_out,
        input  dut_in, busy, done, table_out, match
    );
    modport slave (
        input  start, abort, dut_out,
        output dut_in, busy, done, table_out, match
    );
`endif
endinterface

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives all 8 input rows of a 3-input combinational
// gate, samples its output after a settle time per row, and compares the
// resulting 8-bit table (row 000 -> bit 7) against EXPECTED.
// Optional macro TT_SWEEP_ERRCNT_EN adds a saturating mismatch counter.
//
// state  | meaning
// IDLE   | waiting for start, dut_in parked at 0
// SETTLE | holding dut_in=row, sampling dut_out at end of settle window
// DONE   | one cycle: done pulse, table_out/match freshly updated
module truth_table_sweeper #(
    parameter int         SETTLE_CYCLES = 4,
    parameter logic [7:0] EXPECTED      = 8'h7B
) (
    input  logic                      clk,
    input  logic                      rst_n,
    truth_table_sweeper_if.slave      bus
);
    localparam int            CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [2:0]    row_q, row_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    shadow_q, shadow_d;
    logic [2:0]    dut_in_q, dut_in_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [7:0]    table_q, table_d;
    logic          match_q, match_d;
`ifdef TT_SWEEP_ERRCNT_EN
    logic [7:0]    err_q, err_d;
`endif

    // Next-state and datapath: sequence rows, capture samples, publish result.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        dut_in_d = dut_in_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        table_d  = table_q;
        match_d  = match_q;
`ifdef TT_SWEEP_ERRCNT_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                dut_in_d = 3'd0;
                busy_d   = 1'b0;
                // abort has priority over a simultaneous start
                if (bus.start && !bus.abort) begin
                    state_d  = SETTLE;
                    busy_d   = 1'b1;
                    row_d    = 3'd0;
                    cnt_d    = '0;
                    shadow_d = 8'h00;
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    dut_in_d = 3'd0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d                    = '0;
                    shadow_d[3'd7 - row_q]   = bus.dut_out;
                    if (row_q == 3'd7) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        table_d = shadow_d;
                        match_d = (shadow_d == EXPECTED);
`ifdef TT_SWEEP_ERRCNT_EN
                        if ((shadow_d != EXPECTED) && (err_q != 8'hFF))
                            err_d = err_q + 8'd1;
`endif
                    end else begin
                        row_d    = row_q + 3'd1;
                        dut_in_d = row_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                // done has already been issued, so abort changes nothing here
                state_d  = IDLE;
                busy_d   = 1'b0;
                dut_in_d = 3'd0;
            end
            default: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                dut_in_d = 3'd0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            row_q    <= 3'd0;
            cnt_q    <= '0;
            shadow_q <= 8'h00;
            dut_in_q <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            table_q  <= 8'h00;
            match_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            dut_in_q <= dut_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            table_q  <= table_d;
            match_q  <= match_d;
        end
    end

`ifdef TT_SWEEP_ERRCNT_EN
    // Saturating count of completed sweeps whose table mismatched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 8'h00;
        else        err_q <= err_d;
    end

    assign bus.err_count = err_q;
`endif

    assign bus.dut_in    = dut_in_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.table_out = table_q;
    assign bus.match     = match_q;
endmodule
